// File: rtl/serial_seed_loader_if.sv
// Handshake bundle between the serial bit source, the seed loader and the rotate stage.
interface serial_seed_loader_if #(
  parameter int WIDTH = 4
);
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_start;
  logic             ser_ready;
  logic [WIDTH-1:0] seed;
  logic             seed_valid;
  logic             seed_ready;
  logic             frame_abort;

  modport master (
    output ser_bit, ser_valid, ser_start, seed_ready,
    input  ser_ready, seed, seed_valid, frame_abort
  );

  modport slave (
    input  ser_bit, ser_valid, ser_start, seed_ready,
    output ser_ready, seed, seed_valid, frame_abort
  );
endinterface

// File: rtl/serial_seed_loader.sv
// Assembles a WIDTH-bit seed word from a start-framed serial stream and offers it
// to the rotate stage on a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a bit flagged as frame start; other bits are dropped
// SHIFT | collecting frame bits; a new start restarts the frame with an abort pulse
// HOLD  | complete seed presented; serial input stalled until seed_ready
module serial_seed_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  serial_seed_loader_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic [WIDTH-1:0] sh_q, sh_nx;
  logic [WIDTH-1:0] seed_q, seed_nx;
  logic             seed_valid_q, seed_valid_nx;
  logic             abort_q, abort_nx;
  logic             accept;
  logic [WIDTH-1:0] sh_shifted;
  logic [WIDTH-1:0] sh_fresh;

  assign bus.ser_ready   = (state_q != HOLD);
  assign bus.seed        = seed_q;
  assign bus.seed_valid  = seed_valid_q;
  assign bus.frame_abort = abort_q;

  assign accept = bus.ser_valid && bus.ser_ready;

  // fresh word is the incoming bit shifted into an all-zero register
  assign sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], bus.ser_bit}
                                : {bus.ser_bit, sh_q[WIDTH-1:1]};
  assign sh_fresh   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.ser_bit}
                                : {bus.ser_bit, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_nx;
      cnt_q        <= cnt_nx;
      sh_q         <= sh_nx;
      seed_q       <= seed_nx;
      seed_valid_q <= seed_valid_nx;
      abort_q      <= abort_nx;
    end
  end

  always_comb begin
    state_nx      = state_q;
    cnt_nx        = cnt_q;
    sh_nx         = sh_q;
    seed_nx       = seed_q;
    seed_valid_nx = seed_valid_q;
    abort_nx      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept && bus.ser_start) begin
          sh_nx    = sh_fresh;
          cnt_nx   = CW'(1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          if (bus.ser_start) begin
            abort_nx = 1'b1;
            sh_nx    = sh_fresh;
            cnt_nx   = CW'(1);
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            sh_nx         = sh_shifted;
            seed_nx       = sh_shifted;
            seed_valid_nx = 1'b1;
            cnt_nx        = '0;
            state_nx      = HOLD;
          end else begin
            sh_nx  = sh_shifted;
            cnt_nx = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.seed_ready) begin
          seed_valid_nx = 1'b0;
          state_nx      = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_seed_loader.sv
// Directed bench: one MSB-first loader and one LSB-first loader on a shared clock/reset.
module tb_serial_seed_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_seed_loader_if #(.WIDTH(4)) ia ();
  serial_seed_loader_if #(.WIDTH(4)) ib ();

  serial_seed_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(ia));
  serial_seed_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(ib));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic b, input logic s);
    ia.ser_valid = v;
    ia.ser_bit   = b;
    ia.ser_start = s;
    tick();
  endtask

  task automatic drive_b(input logic v, input logic b, input logic s);
    ib.ser_valid = v;
    ib.ser_bit   = b;
    ib.ser_start = s;
    tick();
  endtask

  initial begin
    ia.ser_valid = 0; ia.ser_bit = 0; ia.ser_start = 0; ia.seed_ready = 0;
    ib.ser_valid = 0; ib.ser_bit = 0; ib.ser_start = 0; ib.seed_ready = 0;

    // 1: reset
    rst = 1'b1;
    tick();
    tick();
    chk("rst_seed", 8'(ia.seed), 8'h0);
    chk("rst_valid", 8'(ia.seed_valid), 8'h0);
    chk("rst_abort", 8'(ia.frame_abort), 8'h0);
    chk("rst_seed_lsb", 8'(ib.seed), 8'h0);
    rst = 1'b0;
    tick();
    chk("rst_ser_ready", 8'(ia.ser_ready), 8'h1);

    // 2: back-to-back MSB-first frame
    ia.seed_ready = 1'b1;
    drive_a(1, 1, 1);
    drive_a(1, 0, 0);
    drive_a(1, 1, 0);
    chk("t2_valid_early", 8'(ia.seed_valid), 8'h0);
    drive_a(1, 1, 0);
    chk("t2_seed", 8'(ia.seed), 8'hb);
    chk("t2_valid", 8'(ia.seed_valid), 8'h1);
    chk("t2_ser_ready_hold", 8'(ia.ser_ready), 8'h0);
    drive_a(0, 0, 0);
    chk("t2_valid_drop", 8'(ia.seed_valid), 8'h0);
    chk("t2_seed_kept", 8'(ia.seed), 8'hb);
    chk("t2_ser_ready_back", 8'(ia.ser_ready), 8'h1);

    // 3: noise in IDLE, then frame with gaps
    drive_a(1, 1, 0);
    drive_a(1, 1, 0);
    drive_a(1, 1, 0);
    chk("t3_noise_valid", 8'(ia.seed_valid), 8'h0);
    drive_a(1, 0, 1);
    drive_a(0, 1, 0);
    drive_a(1, 1, 0);
    drive_a(0, 0, 0);
    drive_a(1, 1, 0);
    drive_a(0, 1, 0);
    chk("t3_gap_valid", 8'(ia.seed_valid), 8'h0);
    drive_a(1, 0, 0);
    chk("t3_seed", 8'(ia.seed), 8'h6);
    chk("t3_valid", 8'(ia.seed_valid), 8'h1);
    drive_a(0, 0, 0);
    chk("t3_valid_drop", 8'(ia.seed_valid), 8'h0);

    // 4: restart mid-frame
    drive_a(1, 1, 1);
    drive_a(1, 0, 0);
    chk("t4_abort_pre", 8'(ia.frame_abort), 8'h0);
    drive_a(1, 1, 1);
    chk("t4_abort_pulse", 8'(ia.frame_abort), 8'h1);
    drive_a(1, 1, 0);
    chk("t4_abort_clear", 8'(ia.frame_abort), 8'h0);
    drive_a(1, 1, 0);
    drive_a(1, 0, 0);
    chk("t4_seed", 8'(ia.seed), 8'he);
    chk("t4_valid", 8'(ia.seed_valid), 8'h1);
    drive_a(0, 0, 0);

    // 5: backpressure
    ia.seed_ready = 1'b0;
    drive_a(1, 0, 1);
    drive_a(1, 1, 0);
    drive_a(1, 0, 0);
    drive_a(1, 1, 0);
    chk("t5_seed", 8'(ia.seed), 8'h5);
    for (int i = 0; i < 5; i++) begin
      drive_a(1, 1, 1);
      chk($sformatf("t5_hold_valid_%0d", i), 8'(ia.seed_valid), 8'h1);
      chk($sformatf("t5_hold_seed_%0d", i), 8'(ia.seed), 8'h5);
      chk($sformatf("t5_hold_ready_%0d", i), 8'(ia.ser_ready), 8'h0);
      chk($sformatf("t5_hold_abort_%0d", i), 8'(ia.frame_abort), 8'h0);
    end
    ia.seed_ready = 1'b1;
    drive_a(0, 0, 0);
    chk("t5_release_valid", 8'(ia.seed_valid), 8'h0);
    chk("t5_release_ready", 8'(ia.ser_ready), 8'h1);
    chk("t5_release_seed", 8'(ia.seed), 8'h5);

    // 6: reset mid-frame, then LSB-first frame
    drive_a(1, 1, 1);
    drive_a(1, 1, 0);
    ia.ser_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_rst_seed", 8'(ia.seed), 8'h0);
    chk("t6_rst_valid", 8'(ia.seed_valid), 8'h0);
    chk("t6_rst_abort", 8'(ia.frame_abort), 8'h0);
    rst = 1'b0;
    tick();
    chk("t6_post_abort", 8'(ia.frame_abort), 8'h0);
    chk("t6_post_ready", 8'(ia.ser_ready), 8'h1);
    // first post-reset bit without start must not complete a stale frame
    drive_a(1, 1, 0);
    drive_a(1, 1, 0);
    drive_a(0, 0, 0);
    chk("t6_no_stale_valid", 8'(ia.seed_valid), 8'h0);

    ib.seed_ready = 1'b1;
    drive_b(1, 1, 1);
    drive_b(1, 1, 0);
    drive_b(1, 0, 0);
    chk("t6_lsb_valid_early", 8'(ib.seed_valid), 8'h0);
    drive_b(1, 1, 0);
    chk("t6_lsb_seed", 8'(ib.seed), 8'hb);
    chk("t6_lsb_valid", 8'(ib.seed_valid), 8'h1);
    drive_b(0, 0, 0);
    chk("t6_lsb_valid_drop", 8'(ib.seed_valid), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
